// File: rtl/pipeline_addsub_seg_if.sv
// Operand/result bus of the carry-segmented adder/subtractor.
// Master drives operands and out_ready; slave returns in_ready and the result.
interface pipeline_addsub_seg_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipeline_addsub_seg.sv
// Carry-segmented pipelined add/sub: one SEG_W-bit segment resolved per stage,
// carry rippled stage to stage, whole-pipe stall on output backpressure.
module seg_add #(parameter int W = 8) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

module pipeline_addsub_seg #(
  parameter int WIDTH = 32,
  parameter int SEGS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_addsub_seg_if.slave  bus
);
  localparam int SEG_W = WIDTH / SEGS;

  if (SEGS < 1 || (WIDTH % SEGS) != 0) begin : g_bad_cfg
    $error("pipeline_addsub_seg: WIDTH must be a non-zero multiple of SEGS");
  end

  logic          adv;
  logic [SEGS:0] vld_pipe;

  assign adv = !vld_pipe[SEGS] || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[SEGS-1:0], bus.in_valid};

  for (genvar k = 0; k <= SEGS; k++) begin : stg
    // hi_q holds the B_eff segments not yet consumed; the last stage reuses it for ovf
    localparam int BW = (k < SEGS) ? WIDTH - k*SEG_W : 1;
    logic [WIDTH-1:0] d_q, d_nxt;   // A in unresolved segments, sum in resolved ones
    logic [BW-1:0]    hi_q, hi_nxt;
    logic             c_q, c_nxt;
    logic             ld;

    if (k == 0) begin : g_in
      assign ld     = adv && bus.in_valid;
      assign d_nxt  = bus.a;
      assign hi_nxt = bus.sub ? ~bus.b : bus.b;
      assign c_nxt  = bus.sub | bus.cin;
    end else begin : g_arith
      logic [SEG_W-1:0] s_seg;

      seg_add #(.W(SEG_W)) u_seg (
        .a  (stg[k-1].d_q[(k-1)*SEG_W +: SEG_W]),
        .b  (stg[k-1].hi_q[SEG_W-1:0]),
        .ci (stg[k-1].c_q),
        .s  (s_seg),
        .co (c_nxt)
      );

      always_comb begin
        d_nxt = stg[k-1].d_q;
        d_nxt[(k-1)*SEG_W +: SEG_W] = s_seg;
      end

      if (k < SEGS) begin : g_mid
        assign hi_nxt = stg[k-1].hi_q[BW+SEG_W-1:SEG_W];
      end else begin : g_last
        // operand MSBs are still intact one stage back; sum MSB is this stage's top bit
        assign hi_nxt = (stg[k-1].d_q[WIDTH-1] == stg[k-1].hi_q[SEG_W-1]) &&
                        (s_seg[SEG_W-1] != stg[k-1].d_q[WIDTH-1]);
      end

      assign ld = adv;
    end

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        d_q  <= '0;
        hi_q <= '0;
        c_q  <= 1'b0;
      end else if (ld) begin
        d_q  <= d_nxt;
        hi_q <= hi_nxt;
        c_q  <= c_nxt;
      end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_pipe[SEGS];
  assign bus.sum       = stg[SEGS].d_q;
  assign bus.cout      = stg[SEGS].c_q;
  assign bus.ovf       = stg[SEGS].hi_q[0];
endmodule

// File: tb/tb_pipeline_addsub_seg.sv
// Directed + random bench for pipeline_addsub_seg (WIDTH=32, SEGS=4) with a
// result scoreboard fed at input transfers and drained at output transfers.
module tb_pipeline_addsub_seg;
  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_out = 0;
  res_t exp_q[$];
  int   out_cycs[$];

  pipeline_addsub_seg_if #(.WIDTH(32)) bus ();

  pipeline_addsub_seg #(.WIDTH(32), .SEGS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Signed/unsigned wide-arithmetic reference
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    res_t        r;
    longint      sa, sb, rs;
    logic [32:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      rs     = sa - sb;
      r.cout = (a >= b);
    end else begin
      rs     = sa + sb + longint'(cin);
      u      = {1'b0, a} + {1'b0, b} + {32'b0, cin};
      r.cout = u[32];
    end
    r.sum = rs[31:0];
    r.ovf = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    res_t got;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        n_out++;
        out_cycs.push_back(cyc);
        got = {bus.sum, bus.cout, bus.ovf};
        if (exp_q.size() == 0) chk("sb_extra", 64'(exp_q.size()), 64'd1);
        else                   chk("sb_res", 64'(got), 64'(exp_q.pop_front()));
      end
      if (rst_n && bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
    end
  endtask

  task automatic counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  // One isolated transaction: latency counted with the capture edge as edge 1
  task automatic single(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic [31:0] es, input logic ec,
                        input logic eo, input string tag);
    int n;
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (n <= 12) begin
      @(negedge clk);
      if (bus.out_valid) break;
      tick();
      n++;
    end
    chk({tag, "_lat"},  64'(n), 64'd5);
    chk({tag, "_sum"},  64'(bus.sum), 64'(es));
    chk({tag, "_cout"}, 64'(bus.cout), 64'(ec));
    chk({tag, "_ovf"},  64'(bus.ovf), 64'(eo));
    tick();
  endtask

  task automatic rand_ops();
    bus.a   = $urandom;
    bus.b   = $urandom;
    bus.cin = 1'($urandom_range(0, 1));
    bus.sub = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int          n0, start, w, idx, t;
    logic        acc;
    logic [33:0] held;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    held = '0;
    rst_n = 1'b1;
    fork
      monitor();
      counter();
    join_none
    #2 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum",       64'(bus.sum),       64'd0);
    chk("rst_cout",      64'(bus.cout),      64'd0);
    chk("rst_ovf",       64'(bus.ovf),       64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    rst_n = 1'b1;
    tick();

    single(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, "t1");
    single(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, "t2a");
    single(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, "t2b");
    single(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "t3a");
    single(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "t3b");
    single(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, "wrap");
    single(32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0, "subcin");

    // streaming: 20 back-to-back
    out_cycs.delete();
    n0 = n_out;
    start = cyc;
    for (int i = 0; i < 20; i++) begin
      rand_ops();
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    w = 0;
    while ((n_out - n0) < 20 && w < 30) begin tick(); w++; end
    chk("str_cnt", 64'(n_out - n0), 64'd20);
    if (out_cycs.size() >= 20) begin
      chk("str_first", 64'(out_cycs[0] - start), 64'd5);
      chk("str_span",  64'(out_cycs[19] - out_cycs[0]), 64'd19);
    end else chk("str_cycs", 64'(out_cycs.size()), 64'd20);

    // backpressure: out_ready low for t=8..10
    n0 = n_out;
    idx = 0;
    t = 0;
    rand_ops();
    while (idx < 10 && t < 60) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = !(t >= 8 && t <= 10);
      @(negedge clk);
      if (t >= 8 && t <= 10) begin
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_valid",    64'(bus.out_valid), 64'd1);
        if (t == 8) held = {bus.sum, bus.cout, bus.ovf};
        else        chk("bp_stable", 64'({bus.sum, bus.cout, bus.ovf}), 64'(held));
      end
      acc = bus.in_ready;
      tick();
      if (acc) begin idx++; rand_ops(); end
      t++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 30) begin tick(); w++; end
    chk("bp_cnt",   64'(n_out - n0), 64'd10);
    chk("bp_empty", 64'(exp_q.size()), 64'd0);

    // reset with three in flight, head stalled at the output
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 20) begin tick(); w++; end
    chk("rst_pre_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_sum",   64'(bus.sum),       64'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    n0 = n_out;
    single(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, "post_rst");
    repeat (8) tick();
    chk("post_rst_cnt", 64'(n_out - n0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
